// File: rtl/bcd_scan_display.sv
// -----------------------------------------------------------------------------
// bcd_scan_display
//
// Captures a packed BCD product from an upstream multiplier on the rising edge
// of its completion flag, then time-multiplexes the latched digits onto a
// single active-high seven-segment bus with a one-hot digit enable.
//
// Parameters
//   N            multiplier operand width in bits (sets the digit count)
//   REFRESH_DIV  clock cycles each digit is held during the scan
//   DIGITS       ((2*N)/3)+1 digits of packed BCD (4 for N=5)
//
// Ports
//   clk       in   single clock, all state updates on its rising edge
//   reset     in   synchronous, active-high reset
//   bcd       in   DIGITS*4 bits packed BCD, digit 0 in bits [3:0]
//   finish    in   upstream completion level; a capture is taken on its rise
//   seg       out  segments {g,f,e,d,c,b,a}, active high
//   an        out  one-hot digit enable, active high
//   valid     out  high once at least one product has been captured
//   captured  out  one-cycle pulse after each capture
//
// Build option
//   BCD_SCAN_LEADING_ZERO_BLANK_EN  when defined, digit positions above the
//   most significant nonzero latched digit are blanked (an=0, seg=0). Digit 0
//   is never blanked, so a latched zero still shows "0".
// -----------------------------------------------------------------------------
module bcd_scan_display #(
   parameter  int N           = 5,
   parameter  int REFRESH_DIV = 4,
   localparam int DIGITS      = ((2*N)/3)+1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DIGITS*4-1:0]   bcd,
   input  logic                  finish,
   output logic [6:0]            seg,
   output logic [DIGITS-1:0]     an,
   output logic                  valid,
   output logic                  captured
);

   // Counter widths stay at least one bit so degenerate parameters still build.
   localparam int IDX_W = (DIGITS > 1)      ? $clog2(DIGITS)      : 1;
   localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

   // --------------------------------------------------------------------------
   // Seven-segment decode, {g,f,e,d,c,b,a}. Non-decimal nibbles show a dash.
   // --------------------------------------------------------------------------
   function automatic logic [6:0] f_seg7(input logic [3:0] i_digit);
      case (i_digit)
         4'd0:    f_seg7 = 7'h3F;
         4'd1:    f_seg7 = 7'h06;
         4'd2:    f_seg7 = 7'h5B;
         4'd3:    f_seg7 = 7'h4F;
         4'd4:    f_seg7 = 7'h66;
         4'd5:    f_seg7 = 7'h6D;
         4'd6:    f_seg7 = 7'h7D;
         4'd7:    f_seg7 = 7'h07;
         4'd8:    f_seg7 = 7'h7F;
         4'd9:    f_seg7 = 7'h6F;
         default: f_seg7 = 7'h40;
      endcase
   endfunction

   // --------------------------------------------------------------------------
   // State
   // --------------------------------------------------------------------------
   logic                  r_finish_d;
   logic [DIGITS*4-1:0]   r_latch;
   logic                  r_valid;
   logic                  r_captured;
   logic [DIV_W-1:0]      r_div;
   logic [IDX_W-1:0]      r_idx;
   logic [6:0]            r_seg;
   logic [DIGITS-1:0]     r_an;

   logic                  w_capture;
   logic                  w_div_wrap;
   logic [IDX_W-1:0]      w_idx_next;
   logic [3:0]            w_digit;
   logic                  w_blank;
   logic [6:0]            w_seg_next;
   logic [DIGITS-1:0]     w_an_next;

   // Rising edge of the completion level; a held-high finish captures once.
   assign w_capture  = finish & ~r_finish_d;
   assign w_div_wrap = (r_div == DIV_LAST);
   assign w_idx_next = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);

   // --------------------------------------------------------------------------
   // Capture path: edge detector, product latch, valid flag, capture pulse.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples the pre-edge values of the others, independent of block order.
      if (reset) begin
         // NOTE: the latch is reset too, so a stale product can never reappear
         // after reset; reset wins over a capture in the same cycle.
         r_finish_d <= 1'b0;
         r_latch    <= '0;
         r_valid    <= 1'b0;
         r_captured <= 1'b0;
      end else begin
         r_finish_d <= finish;
         r_captured <= w_capture;
         if (w_capture) begin
            r_latch <= bcd;
            r_valid <= 1'b1;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Scan timing. Free-running: a capture does not disturb the divider/index.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_div <= '0;
         r_idx <= '0;
      end else if (w_div_wrap) begin
         r_div <= '0;
         r_idx <= w_idx_next;
      end else begin
         r_div <= r_div + DIV_W'(1);
      end
   end

   // --------------------------------------------------------------------------
   // Digit select from the current latch and index.
   // --------------------------------------------------------------------------
   always_comb begin
      // NOTE: default first, so no path through the loop leaves w_digit
      // unassigned and no latch is inferred.
      w_digit = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_digit = r_latch[i*4 +: 4];
         end
      end
   end

`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
   // Highest nonzero digit position; stays 0 for an all-zero latch so digit 0
   // is always shown.
   logic [IDX_W-1:0] w_msd;

   always_comb begin
      w_msd = '0;
      for (int i = 1; i < DIGITS; i++) begin
         if (r_latch[i*4 +: 4] != 4'd0) begin
            w_msd = IDX_W'(i);
         end
      end
   end

   assign w_blank = (r_idx > w_msd);
`else
   assign w_blank = 1'b0;
`endif

   // --------------------------------------------------------------------------
   // Output register. Built from the registered latch and index, so new index
   // or latch contents reach the pins one cycle after they update.
   // --------------------------------------------------------------------------
   always_comb begin
      w_seg_next = 7'h00;
      w_an_next  = '0;
      if (r_valid && !w_blank) begin
         w_seg_next = f_seg7(w_digit);
         w_an_next  = DIGITS'(1) << r_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_seg <= 7'h00;
         r_an  <= '0;
      end else begin
         r_seg <= w_seg_next;
         r_an  <= w_an_next;
      end
   end

   assign seg      = r_seg;
   assign an       = r_an;
   assign valid    = r_valid;
   assign captured = r_captured;

endmodule

// File: tb/tb_bcd_scan_display.sv
// -----------------------------------------------------------------------------
// tb_bcd_scan_display
//
// Self-checking bench for bcd_scan_display (N=5, REFRESH_DIV=4). A behavioural
// model derives the expected outputs each cycle from the count of clock edges
// since reset, the latched digits and the finish history. Directed scenarios
// are followed by randomized capture/reset traffic.
// -----------------------------------------------------------------------------
module tb_bcd_scan_display;

   localparam int N = 5;
   localparam int R = 4;
   localparam int D = ((2*N)/3)+1;

   logic              clk = 1'b0;
   logic              reset;
   logic              finish;
   logic [D*4-1:0]    bcd;
   logic [6:0]        seg;
   logic [D-1:0]      an;
   logic              valid;
   logic              captured;

   always #5 clk = ~clk;

   bcd_scan_display #(
      .N           (N),
      .REFRESH_DIV (R)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bcd      (bcd),
      .finish   (finish),
      .seg      (seg),
      .an       (an),
      .valid    (valid),
      .captured (captured)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // --------------------------------------------------------------------------
   // Reference model
   // --------------------------------------------------------------------------
   bit         m_fd;          // finish seen on the previous edge
   bit         m_valid;
   int         m_t;           // clock edges since reset released
   int         m_lat [D];     // latched digit values
   int         n_capt;

   function automatic logic [6:0] seg_of(input int d);
      logic [6:0] tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
      return (d <= 9) ? tbl[d] : 7'h40;
   endfunction

   function automatic int msd();
      int m = 0;
      for (int i = 0; i < D; i++) if (m_lat[i] != 0) m = i;
      return m;
   endfunction

   // One clock edge: predict, advance, compare, then update the model.
   task automatic tick();
      bit         cap;
      bit         blank;
      int         idx;
      logic [6:0] e_seg;
      logic [D-1:0] e_an;
      cap   = !reset && finish && !m_fd;
      idx   = (m_t / R) % D;
      e_seg = 7'h00;
      e_an  = '0;
      blank = 1'b0;
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
      blank = (idx > msd());
`endif
      if (!reset && m_valid && !blank) begin
         e_an  = D'(1) << idx;
         e_seg = seg_of(m_lat[idx]);
      end
      @(posedge clk);
      #1;
      check("captured", 32'(captured), 32'(cap));
      check("valid",    32'(valid),    32'(!reset && (m_valid || cap)));
      check("an",       32'(an),       32'(e_an));
      check("seg",      32'(seg),      32'(e_seg));
      if (reset) begin
         m_t     = 0;
         m_fd    = 1'b0;
         m_valid = 1'b0;
         for (int i = 0; i < D; i++) m_lat[i] = 0;
      end else begin
         m_t++;
         m_fd = finish;
         if (cap) begin
            m_valid = 1'b1;
            n_capt++;
            for (int i = 0; i < D; i++) m_lat[i] = int'(bcd[i*4 +: 4]);
         end
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int capt_before;
      int waited;
      m_fd    = 1'b0;
      m_valid = 1'b0;
      m_t     = 0;
      n_capt  = 0;
      for (int i = 0; i < D; i++) m_lat[i] = 0;

      // Reset, finish low: everything dark.
      reset  = 1'b1;
      finish = 1'b0;
      bcd    = '0;
      run(2);
      reset = 1'b0;
      run(3);

      // First capture of 0780 and a full scan.
      bcd    = 16'h0780;
      finish = 1'b1;
      run(17);

      // Finish held high while bcd changes: no new capture.
      capt_before = n_capt;
      bcd = 16'h0169;
      run(20);
      check("held_no_recapture", 32'(n_capt), 32'(capt_before));

      // Re-arm, then capture exactly on a digit-advance edge.
      finish = 1'b0;
      tick();
      waited = 0;
      while ((m_t % R) != R - 1 && waited < 2*R) begin
         tick();
         waited++;
      end
      check("advance_align", 32'(m_t % R), 32'(R - 1));
      finish = 1'b1;
      run(17);

      // Non-decimal digit, then reset mid-scan with a simultaneous rise.
      finish = 1'b0;
      tick();
      bcd    = 16'h00A0;
      finish = 1'b1;
      run(9);
      finish = 1'b0;
      tick();
      reset  = 1'b1;
      finish = 1'b1;
      bcd    = 16'h1234;
      run(2);
      reset  = 1'b0;
      finish = 1'b0;
      run(10);
      bcd    = 16'h0005;
      finish = 1'b1;
      run(17);

      // Randomized traffic with leading zeros, dashes and occasional resets.
      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(0, 7) == 0) finish = ~finish;
         for (int i = 0; i < D; i++)
            bcd[i*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 11));
         reset = ($urandom_range(0, 99) == 0);
         tick();
      end
      reset = 1'b0;
      run(4);

      check("captures_seen", 32'(n_capt > 5), 32'(1));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
